// File: rtl/btn_cond_pkg.sv
// Shared constants and helpers for the pushbutton conditioner.
// Imported by the channel and top-level modules.
package btn_cond_pkg;

    localparam int DEBOUNCE_CYCLES_50MHZ_10MS = 500000;
    localparam int DEBOUNCE_CYCLES_SIM = 8;
    localparam int NUM_BUTTONS_DEFAULT = 4;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/button_debounce_conditioner_channel.sv
// One button: 2-FF synchronizer, stability counter, debounced level
// and registered press/release strobes.
module debounce_channel
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ_10MS,
    parameter int CNT_WIDTH = clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic button_n_in,
    output logic button_n_out,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync1;
    logic                 sync2;
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            button_n_out  <= 1'b1;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1         <= button_n_in;
            sync2         <= sync1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            // Any cycle back at the stable level discards the count.
            if (sync2 == button_n_out) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                button_n_out  <= sync2;
                cnt           <= '0;
                press_pulse   <= ~sync2;
                release_pulse <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_debounce_conditioner.sv
// Debounces the active-low board buttons and keeps sticky press
// flags with a maskable interrupt for the button PIO.
module button_debounce_conditioner
    import btn_cond_pkg::*;
#(
    parameter int NUM_BUTTONS = NUM_BUTTONS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ_10MS,
    parameter int CNT_WIDTH = clog2(DEBOUNCE_CYCLES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] button_n_in,
    output logic [NUM_BUTTONS-1:0] button_n_out,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] edge_capture,
    input  logic [NUM_BUTTONS-1:0] edge_clear,
    input  logic [NUM_BUTTONS-1:0] irq_mask,
    output logic                   irq
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH)
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .button_n_in   (button_n_in[i]),
            .button_n_out  (button_n_out[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

    // A press landing with a clear still sets, so no press is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= press_pulse | (edge_capture & ~edge_clear);
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule
